// File: rtl/store_rmw_ctrl.sv
// rtl/store_rmw_ctrl.sv - sub-word store controller (read-merge-write) with per-phase ack timeout
// Optional: STORE_MISALIGN_TRAP_EN traps misaligned SH/SW without touching memory.
module store_rmw_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        misalign;
    logic        timeout_hit;

`ifdef STORE_MISALIGN_TRAP_EN
    assign misalign = ((size_i == 2'b01) && addr_i[0]) ||
                      ((size_i[1] == size_i[0]) && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // An ack arriving in the last allowed cycle wins over the timeout.
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    size_d  = size_i;
                    data_d  = wdata_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (misalign) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (size_i[1] == size_i[0]) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem_ack_i) begin
                    data_d  = mem_rdata_i;
                    state_d = S_MERGE;
                end else if (timeout_hit) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_MERGE: begin
                if (size_q == 2'b10) begin
                    data_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                end else begin
                    data_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                end
                cnt_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ack_i) begin
                    state_d = S_FIN;
                end else if (timeout_hit) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FIN: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        mem_req_o   = (state_q == S_READ) || (state_q == S_WRITE);
        mem_we_o    = (state_q == S_WRITE);
        done_o      = (state_q == S_FIN);
        err_o       = (state_q == S_FIN) && err_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = data_q;
    end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb/tb_store_rmw_ctrl.sv - directed self-checking bench for store_rmw_ctrl
module tb_store_rmw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .size_i      (size),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int          r_done_cyc, r_err, r_dones, r_writes, r_reads, r_req_cyc, r_we_seen;
    logic [31:0] r_waddr, r_wdat;

    // Issues one store and plays the memory: ack after dly waiting cycles in each phase.
    task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly, input bit restart);
        int ph;
        r_done_cyc = -1; r_err = 0; r_dones = 0; r_writes = 0; r_reads = 0;
        r_req_cyc = 0; r_we_seen = 0; r_waddr = '0; r_wdat = '0; ph = 0;
        size = sz; addr = a; wdata = wd; mem_rdata = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            start = restart && (cyc == 2);
            if (start) begin size = 2'b00; addr = 32'h999; wdata = '0; end
            if (mem_req) begin
                ph++;
                r_req_cyc++;
            end else begin
                ph = 0;
            end
            mem_ack = mem_req && (ph > dly);
            if (mem_we) r_we_seen = 1;
            if (mem_ack && mem_we) begin
                r_writes++; r_waddr = mem_addr; r_wdat = mem_wdata;
            end
            if (mem_ack && !mem_we) r_reads++;
            if (done) begin
                r_dones++; r_done_cyc = cyc; r_err = int'(err);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; size = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'b10, 32'h103, 32'h0000_00AB, 32'h1122_3344, 0, 0);
        check("sb_data", r_wdat, 32'hAB22_3344);
        check("sb_addr", r_waddr, 32'h100);
        check("sb_cyc", r_done_cyc, 4);
        check("sb_dones", r_dones, 1);
        check("sb_err", r_err, 0);
        check("sb_reads", r_reads, 1);

        run_op(2'b01, 32'h202, 32'h0000_BEEF, 32'h1122_3344, 3, 1);
        check("sh_data", r_wdat, 32'hBEEF_3344);
        check("sh_addr", r_waddr, 32'h200);
        check("sh_cyc", r_done_cyc, 10);
        check("sh_dones", r_dones, 1);
        check("sh_err", r_err, 0);
        check("sh_writes", r_writes, 1);

        run_op(2'b10, 32'h101, 32'hFFFF_FF77, 32'h1122_3344, 0, 0);
        check("sb1_data", r_wdat, 32'h1122_7744);

        run_op(2'b00, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 0);
        check("sw_data", r_wdat, 32'hDEAD_BEEF);
        check("sw_addr", r_waddr, 32'h40);
        check("sw_reads", r_reads, 0);
        check("sw_writes", r_writes, 1);
        check("sw_cyc", r_done_cyc, 2);

        run_op(2'b10, 32'h10, 32'h55, 32'h0, 100, 0);
        check("tor_cyc", r_done_cyc, 5);
        check("tor_err", r_err, 1);
        check("tor_reqcyc", r_req_cyc, 4);
        check("tor_we", r_we_seen, 0);
        check("tor_dones", r_dones, 1);

        run_op(2'b00, 32'h20, 32'h1234_5678, 32'h0, 4, 0);
        check("tow_cyc", r_done_cyc, 5);
        check("tow_err", r_err, 1);
        check("tow_writes", r_writes, 0);

`ifdef STORE_MISALIGN_TRAP_EN
        run_op(2'b01, 32'h101, 32'h0000_BEEF, 32'h1122_3344, 0, 0);
        check("mis_sh_cyc", r_done_cyc, 1);
        check("mis_sh_err", r_err, 1);
        check("mis_sh_req", r_req_cyc, 0);
        run_op(2'b00, 32'h42, 32'hCAFE_F00D, 32'h0, 0, 0);
        check("mis_sw_err", r_err, 1);
        check("mis_sw_req", r_req_cyc, 0);
`else
        run_op(2'b01, 32'h101, 32'h0000_BEEF, 32'h1122_3344, 0, 0);
        check("mis_sh_data", r_wdat, 32'h1122_BEEF);
        check("mis_sh_addr", r_waddr, 32'h100);
        check("mis_sh_err", r_err, 0);
        check("mis_sh_cyc", r_done_cyc, 4);
        run_op(2'b00, 32'h42, 32'hCAFE_F00D, 32'h0, 0, 0);
        check("mis_sw_addr", r_waddr, 32'h40);
        check("mis_sw_err", r_err, 0);
`endif

        size = 2'b00; addr = 32'h40; wdata = 32'h1111_2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rw_req_pre", 32'(mem_req && mem_we), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rw_req", 32'(mem_req), 0);
        check("rw_busy", 32'(busy), 0);
        check("rw_done", 32'(done), 0);
        r_dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) r_dones++;
            @(posedge clk); #1;
        end
        check("rw_nodone", r_dones, 0);
        run_op(2'b10, 32'h102, 32'h0000_0099, 32'hAABB_CCDD, 0, 0);
        check("rw_sb_data", r_wdat, 32'hAA99_CCDD);
        check("rw_sb_cyc", r_done_cyc, 4);

        size = 2'b10; addr = 32'h8; wdata = 32'h1; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        check("sr_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("sr_req", 32'(mem_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_rmw_ctrl.md
STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, maximum cycles waiting for MEM_ACK in one memory phase (range 1..255).
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 START  in  1  one-cycle store request; sampled only in IDLE.
REQ-005 SIZE  in  2  00 word (SW), 01 half (SH), 10 byte (SB); 11 treated as word.
REQ-006 ADDR  in  32  byte address of the store.
REQ-007 WDATA  in  32  store data, right-justified for SB/SH.
REQ-008 BUSY  out  1  high in every state except IDLE.
REQ-009 DONE  out  1  one-cycle completion pulse.
REQ-010 ERR  out  1  one-cycle pulse, concurrent with DONE, on timeout or misalignment.
REQ-011 MEM_REQ  out  1  memory request, held until MEM_ACK.
REQ-012 MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ.
REQ-013 MEM_ADDR  out  32  word-aligned address {ADDR[31:2],2'b00}.
REQ-014 MEM_WDATA  out  32  merged word to write.
REQ-015 MEM_RDATA  in  32  read data; valid in the cycle MEM_ACK=1.
REQ-016 MEM_ACK  in  1  completes the current memory phase.

Function
REQ-017 The FSM SHALL have states IDLE, READ, MERGE, WRITE, FIN.
REQ-018 In IDLE with START=1, ADDR/WDATA/SIZE SHALL be latched; SW goes to WRITE, SH/SB go to READ.
REQ-019 START while BUSY=1 SHALL be ignored.
REQ-020 READ: MEM_REQ=1, MEM_WE=0; on MEM_ACK, MEM_RDATA SHALL be captured and the FSM SHALL go to MERGE.
REQ-021 MERGE, one cycle: SB replaces byte lane ADDR[1:0] (bits 8k+7:8k, little-endian) with WDATA[7:0]; SH replaces halfword lane ADDR[1] with WDATA[15:0]; all other bits keep the read value.
REQ-022 WRITE: MEM_REQ=1, MEM_WE=1, MEM_WDATA = merged word (SW: latched WDATA); on MEM_ACK, go to FIN.
REQ-023 FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-024 MEM_ACK outside READ/WRITE SHALL be ignored.
REQ-025 A wait counter SHALL clear on entry to READ/WRITE and increment each cycle without MEM_ACK.
REQ-026 Timeout: when the counter reaches ACK_TIMEOUT, drop MEM_REQ, go to FIN with ERR=1; no write is issued.
REQ-027 MEM_ACK in the same cycle the counter reaches ACK_TIMEOUT SHALL count as success; no ERR.
REQ-028 Minimum latency with MEM_ACK immediate: SB/SH START at cycle 0 -> DONE at cycle 4; SW -> DONE at cycle 2.
REQ-029 MEM_ADDR/MEM_WDATA SHALL stay stable while MEM_REQ=1.

Reset
REQ-030 RESET=1 SHALL force IDLE at the next edge from any state and abort the access.
REQ-031 Reset values: BUSY, DONE, ERR, MEM_REQ, MEM_WE = 0; MEM_ADDR, MEM_WDATA, counter, latched operands = 0.
REQ-032 A START concurrent with RESET SHALL be ignored.

Configuration
REQ-033 Macro STORE_MISALIGN_TRAP_EN defined: SH with ADDR[0]=1 or SW with ADDR[1:0]!=0 SHALL skip memory, go IDLE->FIN, pulse ERR with DONE.
REQ-034 Macro undefined: no misalignment check; SH uses lane ADDR[1]; SW ignores ADDR[1:0]; ERR only on timeout.

Verification
REQ-035 SB ADDR=0x103, WDATA=0xAB, MEM_RDATA=0x11223344, immediate ACK -> write 0xAB223344 to 0x100, DONE at cycle 4.
REQ-036 SH ADDR=0x202, WDATA=0xBEEF, RDATA=0x11223344, ACK delayed 3 cycles each phase -> write 0xBEEF3344 to 0x200, DONE once.
REQ-037 SW ADDR=0x40, WDATA=0xDEADBEEF -> no read phase, one write of 0xDEADBEEF, DONE at cycle 2.
REQ-038 ACK_TIMEOUT=4, no MEM_ACK in READ -> MEM_REQ drops after 4 wait cycles, DONE=ERR=1 together, MEM_WE never 1.
REQ-039 RESET asserted during WRITE -> next cycle MEM_REQ=0, BUSY=0, no DONE; a following SB completes normally.
REQ-040 With STORE_MISALIGN_TRAP_EN, SH ADDR=0x101 -> DONE=ERR=1 at cycle 1, MEM_REQ never 1; without it, write merges lane 0.
